blink_period_meter: RTL

Measures an incoming slow blink/toggle signal against the 50 MHz system clock. Synchronises the asynchronous input, detects rising edges, and reports period and high time in clock cycles once per input period. Loss-of-signal detection via a programmable timeout. Sits at the receiving end of the board's blink/divided-clock outputs, for self-check and frequency readback.

---
 rtl/blink_pkg.sv | 13 +
 rtl/sync_edge_det.sv | 38 +++
 rtl/blink_period_meter.sv | 116 +++++++++++
 3 files changed

// File: rtl/blink_pkg.sv
// Shared types and constants for the blink period meter.
package blink_pkg;

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_MEASURE = 1'b1
  } state_t;

  localparam int unsigned CLK_HZ          = 32'd50000000;
  // Five seconds of silence at the system clock rate
  localparam int unsigned TIMEOUT_DEFAULT = 32'd5 * CLK_HZ;

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchroniser for an asynchronous input plus a rising-edge detector.
module sync_edge_det (
  input  logic clk,
  input  logic set,
  input  logic din,
  output logic lvl,
  output logic rise
);

  logic       meta_r;
  logic       lvl_r;
  logic       lvl_d_r;
  logic       armed_r;
  logic [1:0] fill_r;

  // Synchroniser pipeline, edge history, and arming once a genuine low has been seen
  always_ff @(posedge clk) begin
    if (set) begin
      meta_r  <= 1'b0;
      lvl_r   <= 1'b0;
      lvl_d_r <= 1'b0;
      fill_r  <= 2'b00;
      armed_r <= 1'b0;
    end else begin
      meta_r  <= din;
      lvl_r   <= meta_r;
      lvl_d_r <= lvl_r;
      fill_r  <= {fill_r[0], 1'b1};
      armed_r <= armed_r | (fill_r[1] & ~lvl_r);
    end
  end

  // The reset zeros in the pipeline are not a real low, so an input held
  // high through reset release must not look like a rising edge.
  assign lvl  = lvl_r;
  assign rise = lvl_r & ~lvl_d_r & armed_r;

endmodule

// File: rtl/blink_period_meter.sv
// Measures period and high time of a slow asynchronous blink input, with loss-of-signal timeout.
module blink_period_meter
  import blink_pkg::*;
#(
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic             clk_50MHz,
  input  logic             set,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period_cycles,
  output logic [CNT_W-1:0] high_cycles,
  output logic             meas_valid,
  output logic             locked,
  output logic             lost
);

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] ONE_C     = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] ZERO_C    = {CNT_W{1'b0}};

  state_t           state_r;
  state_t           state_s;
  logic             lvl_s;
  logic             rise_s;
  logic             start_s;
  logic             measure_s;
  logic             timeout_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] hcnt_r;

  sync_edge_det u_sync (
    .clk  (clk_50MHz),
    .set  (set),
    .din  (sig_in),
    .lvl  (lvl_s),
    .rise (rise_s)
  );

  // FSM state register
  always_ff @(posedge clk_50MHz) begin
    if (set) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next state and per-cycle actions; an edge coinciding with the timeout count wins
  always_comb begin
    state_s   = state_r;
    start_s   = 1'b0;
    measure_s = 1'b0;
    timeout_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (rise_s) begin
          state_s = ST_MEASURE;
          start_s = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_MEASURE: begin
        if (rise_s) begin
          state_s   = ST_MEASURE;
          measure_s = 1'b1;
        end else if (cnt_r == TIMEOUT_C) begin
          state_s   = ST_IDLE;
          timeout_s = 1'b1;
        end else begin
          state_s = ST_MEASURE;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Counters and registered outputs
  always_ff @(posedge clk_50MHz) begin
    if (set) begin
      cnt_r         <= ZERO_C;
      hcnt_r        <= ZERO_C;
      period_cycles <= ZERO_C;
      high_cycles   <= ZERO_C;
      meas_valid    <= 1'b0;
      locked        <= 1'b0;
      lost          <= 1'b0;
    end else begin
      meas_valid <= measure_s;
      lost       <= timeout_s;
      if (start_s || measure_s) begin
        cnt_r  <= ONE_C;
        hcnt_r <= ONE_C;
      end else if ((state_r == ST_MEASURE) && !timeout_s) begin
        cnt_r  <= cnt_r + ONE_C;
        hcnt_r <= hcnt_r + {{(CNT_W-1){1'b0}}, lvl_s};
      end else begin
        cnt_r  <= ZERO_C;
        hcnt_r <= ZERO_C;
      end
      if (measure_s) begin
        period_cycles <= cnt_r;
        high_cycles   <= hcnt_r;
        locked        <= 1'b1;
      end else if (timeout_s) begin
        locked <= 1'b0;
      end else begin
        locked <= locked;
      end
    end
  end

endmodule
